ifetch_queue: RTL

- Instruction-fetch front end between the 2Kx32 instruction RAM and the decode stage of the pipeline.
- Generates word addresses for the synchronous RAM (1-cycle read latency) and captures returned words into a small prefetch queue.
- Presents {ir, ir_pc} to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding in-flight data.

---
 rtl/ifq_pkg.sv | 17 +
 rtl/ifq_fifo.sv | 79 +++++++
 rtl/ifetch_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// Shared widths, queue entry type and sizing helper for the instruction-fetch queue.
package ifq_pkg;

    localparam int unsigned IFQ_ADDR_W = 11;
    localparam int unsigned IFQ_DATA_W = 32;

    typedef struct packed {
        logic [IFQ_ADDR_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] ir;
    } ifq_entry_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned ifq_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular FIFO of fetch-queue entries with synchronous flush; head is read combinationally.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = ifq_entry_t,
    localparam int unsigned CntW   = ifq_cnt_w(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  entry_t          data_i,
    input  logic            pop_i,
    output entry_t          head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: drives a 1-cycle-latency RAM and queues words for decode.
// Define IFQ_BYPASS_EN to forward a returning word straight to decode when the queue is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned ADDR_W   = IFQ_ADDR_W,
    parameter int unsigned DATA_W   = IFQ_DATA_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_oen,
    input  logic [DATA_W-1:0] im_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              id_ready
);

    localparam int unsigned CntW = ifq_cnt_w(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ir;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;

    entry_t            head;
    entry_t            resp;
    logic [CntW-1:0]   count;
    logic [CntW:0]     occupancy;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              resp_valid;
    logic              bypass;
    logic              pop;
    logic              issue;

    assign im_oen     = ~rst_n;
    assign im_addr    = redirect_valid ? redirect_addr : fetch_pc_q;
    assign resp_valid = inflight_q & ~redirect_valid;
    assign resp       = '{pc: req_pc_q, ir: im_q};

`ifdef IFQ_BYPASS_EN
    assign bypass = fifo_empty & resp_valid;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        ir_valid  = rst_n & (~fifo_empty | bypass);
        ir        = bypass ? im_q : head.ir;
        ir_pc     = bypass ? req_pc_q : head.pc;
        pop       = ir_valid & id_ready & ~redirect_valid;
        fifo_pop  = pop & ~bypass;
        // A bypassed word that decode takes immediately never enters the queue.
        fifo_push = resp_valid & ~(bypass & pop);
        // Slots committed next cycle: queued words plus the one in flight, minus this pop.
        occupancy = (CntW + 1)'(count) + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
        issue     = redirect_valid | (occupancy < (CntW + 1)'(DEPTH));
    end

    always_comb begin
        inflight_d = issue;
        fetch_pc_d = issue ? im_addr + 1'b1 : fetch_pc_q;
        req_pc_d   = issue ? im_addr : req_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= ADDR_W'(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    ifq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (fifo_push),
        .data_i  (resp),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .count_o (count),
        .empty_o (fifo_empty)
    );

endmodule
